// File: rtl/boot_loader_if.sv
// Image stream into the boot loader: valid/ready words with an end-of-image marker.
// The source drives valid/data/last; the loader drives ready.
interface boot_loader_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_ready;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready
   );
endinterface

// File: rtl/boot_loader.sv
// Streams a program image into main memory from address 0, then raises cpu_run; 1-cycle accept-to-write latency,
// in_ready is high only in LOAD. Optional `BOOT_CHECKSUM_EN: the last word is a checksum of the image, not written.
module boot_loader #(
   parameter int DEPTH     = 2048,
   parameter int CNT_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   boot_loader_if.slave         in_s,
   input  logic                 reload,
   output logic [31:0]          mem_waddr,
   output logic [31:0]          mem_wdata,
   output logic                 mem_wen,
   output logic                 cpu_run,
   output logic [CNT_WIDTH-1:0] word_count,
   output logic                 error
);

   typedef enum logic [1:0] {
      S_LOAD,
      S_FLUSH,
      S_RUN,
      S_ERROR
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   in_ready_q;
   logic   accept;
   logic   full;
   logic   wr_d;
   logic   cnt_clr;

`ifdef BOOT_CHECKSUM_EN
   logic [31:0] sum_q;
`endif

   assign in_s.in_ready = in_ready_q;
   assign accept        = in_s.in_valid & in_ready_q;
   assign full          = (word_count == CNT_WIDTH'(DEPTH));
   assign cpu_run       = (state_q == S_RUN);
   assign error         = (state_q == S_ERROR);

   always_comb begin
      state_d = state_q;
      wr_d    = 1'b0;
      cnt_clr = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (accept) begin
`ifdef BOOT_CHECKSUM_EN
               // The checksum word is compared, never stored, so it cannot overflow memory.
               if (in_s.in_last) begin
                  state_d = (in_s.in_data == sum_q) ? S_FLUSH : S_ERROR;
               end else if (full) begin
                  state_d = S_ERROR;
               end else begin
                  wr_d = 1'b1;
               end
`else
               if (full) begin
                  state_d = S_ERROR;
               end else begin
                  wr_d = 1'b1;
                  if (in_s.in_last) begin
                     state_d = S_FLUSH;
                  end
               end
`endif
            end
         end
         S_FLUSH: begin
            state_d = S_RUN;
         end
         S_RUN, S_ERROR: begin
            if (reload) begin
               state_d = S_LOAD;
               cnt_clr = 1'b1;
            end
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered ready keeps it low for the first cycle out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_q <= 1'b0;
         mem_wen    <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
      end else begin
         in_ready_q <= (state_d == S_LOAD);
         mem_wen    <= wr_d;
         if (wr_d) begin
            mem_waddr  <= 32'(word_count);
            mem_wdata  <= in_s.in_data;
            word_count <= word_count + CNT_WIDTH'(1);
         end else if (cnt_clr) begin
            word_count <= '0;
         end
      end
   end

`ifdef BOOT_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
      end else if (cnt_clr) begin
         sum_q <= '0;
      end else if (wr_d) begin
         sum_q <= sum_q + in_s.in_data;
      end
   end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: image-level reference model feeds an expected-write scoreboard
// that a negedge monitor drains; end-of-load state is checked at fixed offsets from the last accept.
module tb_boot_loader;
   localparam int DEPTH     = 4;
   localparam int CNT_WIDTH = 3;
`ifdef BOOT_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 reload = 1'b0;
   logic [31:0]          mem_waddr;
   logic [31:0]          mem_wdata;
   logic                 mem_wen;
   logic                 cpu_run;
   logic [CNT_WIDTH-1:0] word_count;
   logic                 error;

   boot_loader_if bus ();

   boot_loader #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_s       (bus),
      .reload     (reload),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wen    (mem_wen),
      .cpu_run    (cpu_run),
      .word_count (word_count),
      .error      (error)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] exp_q[$];
   logic [31:0] img[$];
   logic [63:0] mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Every memory write must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (rst && mem_wen) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_waddr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("mem_write", {mem_waddr, mem_wdata}, mon_e);
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_mem_wen"}, mem_wen, 0);
      chk({tag, "_mem_waddr"}, mem_waddr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_cpu_run"}, cpu_run, 0);
      chk({tag, "_word_count"}, word_count, 0);
      chk({tag, "_error"}, error, 0);
   endtask

   task automatic send(input logic [31:0] d, input logic l, input int gap);
      int t;
      @(negedge clk);
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      t = 0;
      while (!bus.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         n_checks++;
         $display("FAIL in_ready_timeout: in_ready 0 after %0d cycles, expected 1", t);
      end
   endtask

   // Reference model works on the whole image: which words land where, and how the load ends.
   task automatic run_load(input int gap_mode);
      int          data_n;
      int          send_n;
      int          exp_cnt;
      bit          exp_err;
      logic [31:0] sum;
      data_n = CSUM ? img.size() - 1 : img.size();
      sum    = 32'd0;
      if (data_n > DEPTH) begin
         exp_err = 1'b1;
         exp_cnt = DEPTH;
         send_n  = DEPTH + 1;
      end else begin
         exp_cnt = data_n;
         send_n  = img.size();
         for (int i = 0; i < data_n; i++) sum += img[i];
         exp_err = CSUM && (img[img.size()-1] != sum);
      end
      for (int i = 0; i < exp_cnt; i++) exp_q.push_back({32'(i), img[i]});
      for (int i = 0; i < send_n; i++)
         send(img[i], (i == img.size() - 1), (gap_mode < 0) ? int'($urandom_range(2)) : gap_mode);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("cpu_run_after_accept", cpu_run, 0);
      chk("error_after_accept", error, exp_err);
      @(negedge clk);
      chk("cpu_run", cpu_run, !exp_err);
      chk("error", error, exp_err);
      chk("word_count", word_count, exp_cnt);
      chk("in_ready_idle", bus.in_ready, 0);
      chk("writes_drained", exp_q.size(), 0);
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk("reload_cpu_run", cpu_run, 0);
      chk("reload_error", error, 0);
      chk("reload_word_count", word_count, 0);
      chk("reload_in_ready", bus.in_ready, 1);
   endtask

   task automatic add_csum(input bit good);
      logic [31:0] s;
      s = 32'd0;
      foreach (img[i]) s += img[i];
      img.push_back(good ? s : s + 32'd1 + 32'($urandom_range(1000)));
   endtask

   initial begin
      int n;
      bus.in_valid = 1'b0;
      bus.in_data  = 32'd0;
      bus.in_last  = 1'b0;
      #3;
      chk_reset_vals("reset");
      #9 rst = 1'b1;
      #1 chk("in_ready_before_edge", bus.in_ready, 0);
      @(negedge clk);
      chk("in_ready_first_edge", bus.in_ready, 1);

      // Basic back-to-back load, then the same image with 2-cycle bubbles.
      for (int g = 0; g <= 2; g += 2) begin
         img = '{32'h11, 32'h22, 32'h33};
         if (CSUM) img.push_back(32'h66);
         run_load(g);
         do_reload();
      end

      // Overflow by one word, then an image of exactly DEPTH words.
      img = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
      if (CSUM) add_csum(1'b1);
      run_load(0);
      do_reload();
      img = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      if (CSUM) add_csum(1'b1);
      run_load(1);
      do_reload();

`ifdef BOOT_CHECKSUM_EN
      img = '{32'd1, 32'd2, 32'd3, 32'd6};
      run_load(0);
      do_reload();
      img = '{32'd1, 32'd2, 32'd3, 32'd7};
      run_load(0);
      do_reload();
      img = '{32'd0};
      run_load(0);
      do_reload();
`endif

      img = '{32'hAA};
      if (CSUM) img.push_back(32'hAA);
      run_load(0);
      do_reload();

      // Async reset between edges after two accepts; the pending write must vanish.
      exp_q.push_back({32'd0, 32'hC0});
      exp_q.push_back({32'd1, 32'hC1});
      send(32'hC0, 1'b0, 0);
      send(32'hC1, 1'b0, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      bus.in_valid = 1'b0;
      #1 chk_reset_vals("async_reset");
      exp_q.delete();
      #1 rst = 1'b1;

      // Random images, including overflow and bad checksums; each must start at address 0.
      for (int it = 0; it < 30; it++) begin
         n = CSUM ? int'($urandom_range(5)) : int'($urandom_range(6, 1));
         img.delete();
         for (int i = 0; i < n; i++) img.push_back($urandom);
         if (CSUM) add_csum($urandom_range(1) == 1);
         run_load(-1);
         do_reload();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
